// File: rtl/stream_sort_engine_pkg.sv
// Shared types for the stream sort engine: FSM states, per-cell record and
// the selector a cell uses to pick its next contents.
package stream_sort_engine_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_TAG_W  = 8;
   localparam int DEF_DEPTH  = 64;

   typedef enum logic {
      LOAD  = 1'b0,
      DRAIN = 1'b1
   } sort_state_e;

   // Cell record at the default widths; modules with overridden widths
   // declare a local copy of the same layout.
   typedef struct packed {
      logic                  vld;
      logic [DEF_DATA_W-1:0] key;
      logic [DEF_TAG_W-1:0]  tag;
   } sort_cell_t;

   typedef enum logic [1:0] {
      SEL_HOLD  = 2'd0,
      SEL_INPUT = 2'd1,
      SEL_LOWER = 2'd2,
      SEL_UPPER = 2'd3
   } cell_sel_e;

endpackage

// File: rtl/stream_sort_engine_if.sv
// Input and output valid/ready streams of the sort engine. The master side
// produces input beats and consumes drained beats; the slave is the engine.
interface stream_sort_engine_if #(
   parameter int DATA_W = 8,
   parameter int TAG_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_key;
   logic [TAG_W-1:0]  in_tag;
   logic              in_last;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_key;
   logic [TAG_W-1:0]  out_tag;
   logic              out_last;

   modport master (
      output in_valid, in_key, in_tag, in_last, out_ready,
      input  in_ready, out_valid, out_key, out_tag, out_last
   );

   modport slave (
      input  in_valid, in_key, in_tag, in_last, out_ready,
      output in_ready, out_valid, out_key, out_tag, out_last
   );
endinterface

// File: rtl/stream_sort_engine_cell.sv
// One sort cell: holds an occupied bit, key and tag, decides whether the
// incoming key beats its contents, and picks its next value from hold,
// the input beat, the lower neighbour (insert shift) or the upper
// neighbour (drain shift).
module sort_cell
   import stream_sort_engine_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TAG_W  = DEF_TAG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              insert_i,
   input  logic              shift_i,
   input  logic              descend_i,
   input  logic [DATA_W-1:0] in_key_i,
   input  logic [TAG_W-1:0]  in_tag_i,
   input  logic              beats_prev_i,
   input  logic              lower_vld_i,
   input  logic [DATA_W-1:0] lower_key_i,
   input  logic [TAG_W-1:0]  lower_tag_i,
   input  logic              upper_vld_i,
   input  logic [DATA_W-1:0] upper_key_i,
   input  logic [TAG_W-1:0]  upper_tag_i,
   output logic              beats_o,
   output logic              vld_o,
   output logic [DATA_W-1:0] key_o,
   output logic [TAG_W-1:0]  tag_o
);

   typedef struct packed {
      logic              vld;
      logic [DATA_W-1:0] key;
      logic [TAG_W-1:0]  tag;
   } cell_t;

   cell_t     cell_q;
   cell_t     cell_d;
   cell_sel_e sel;

   // An empty cell is always beaten; otherwise a strict compare keeps
   // equal keys in arrival order.
   always_comb begin
      beats_o = !cell_q.vld |
                (descend_i ? (in_key_i > cell_q.key) : (in_key_i < cell_q.key));
   end

   // Because beats is monotonic up the array, the insertion point is the
   // one cell that beats while its lower neighbour does not.
   always_comb begin
      sel = SEL_HOLD;
      if (insert_i) begin
         if (beats_prev_i) begin
            sel = SEL_LOWER;
         end else if (beats_o) begin
            sel = SEL_INPUT;
         end
      end else if (shift_i) begin
         sel = SEL_UPPER;
      end
   end

   // Next cell contents from the selected source.
   always_comb begin
      cell_d = cell_q;
      case (sel)
         SEL_INPUT: cell_d = '{vld: 1'b1,        key: in_key_i,    tag: in_tag_i};
         SEL_LOWER: cell_d = '{vld: lower_vld_i, key: lower_key_i, tag: lower_tag_i};
         SEL_UPPER: cell_d = '{vld: upper_vld_i, key: upper_key_i, tag: upper_tag_i};
         default:   cell_d = cell_q;
      endcase
   end

   // Cell storage; a flush wins over any insert or drain shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cell_q <= '0;
      end else if (clear_i) begin
         cell_q <= '0;
      end else begin
         cell_q <= cell_d;
      end
   end

   assign vld_o = cell_q.vld;
   assign key_o = cell_q.key;
   assign tag_o = cell_q.tag;

endmodule

// File: rtl/stream_sort_engine.sv
// Framed insertion sorter: loads a frame of (key, tag) beats into a sorted
// cell array, then drains it serially from cell 0. Owns the LOAD/DRAIN FSM,
// the occupancy count, the truncation flag and both handshakes.
module stream_sort_engine
   import stream_sort_engine_pkg::*;
#(
   parameter int  DATA_W = DEF_DATA_W,
   parameter int  TAG_W  = DEF_TAG_W,
   parameter int  DEPTH  = DEF_DEPTH,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear_i,
   input  logic                    descend_i,
   stream_sort_engine_if.slave     bus,
   output logic [CNT_W-1:0]        count_o,
   output logic                    truncated_o,
   output logic [DEPTH*DATA_W-1:0] sorted_keys_o,
   output logic [DEPTH*TAG_W-1:0]  sorted_tags_o,
   output logic [DEPTH-1:0]        sorted_vld_o
);

   localparam logic [CNT_W-1:0] CNT_FULL_M1 = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   sort_state_e state_q;
   sort_state_e state_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic truncated_q;
   logic truncated_d;
   logic descend_q;
   logic descend_d;

   logic inReady;
   logic outValid;
   logic outLast;
   logic inAcc;
   logic outAcc;

   logic [DEPTH-1:0]  beatsW;
   logic [DEPTH-1:0]  vldW;
   logic [DATA_W-1:0] keyW [DEPTH];
   logic [TAG_W-1:0]  tagW [DEPTH];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: close the frame on in_last or when the array fills, and
   // reopen once the final beat has been taken downstream.
   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD: begin
            if (inAcc && (bus.in_last || (count_q == CNT_FULL_M1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (outAcc && (count_q == CNT_ONE)) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
      if (clear_i) begin
         state_d = LOAD;
      end
   end

   // Handshake outputs depend only on registered state, so neither valid
   // feeds its own ready combinationally.
   always_comb begin
      inReady  = (state_q == LOAD) && (count_q < CNT_FULL);
      outValid = (state_q == DRAIN);
      outLast  = (state_q == DRAIN) && (count_q == CNT_ONE);
   end

   assign inAcc  = bus.in_valid & inReady;
   assign outAcc = outValid & bus.out_ready;

   // Occupancy, truncation flag and latched sort direction.
   always_comb begin
      count_d     = count_q;
      truncated_d = truncated_q;
      descend_d   = descend_q;
      if (clear_i) begin
         count_d     = '0;
         truncated_d = 1'b0;
      end else if (inAcc) begin
         count_d = count_q + CNT_ONE;
         if (count_q == '0) begin
            descend_d = descend_i;
         end
         if (count_q == CNT_FULL_M1) begin
            truncated_d = !bus.in_last;
         end
      end else if (outAcc) begin
         count_d = count_q - CNT_ONE;
         if (count_q == CNT_ONE) begin
            truncated_d = 1'b0;
         end
      end
   end

   // Datapath registers alongside the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         truncated_q <= 1'b0;
         descend_q   <= 1'b0;
      end else begin
         count_q     <= count_d;
         truncated_q <= truncated_d;
         descend_q   <= descend_d;
      end
   end

   // Cell array: bottom cell sees no lower beat, top cell drains in zeros.
   for (genvar i = 0; i < DEPTH; i++) begin : gCell
      logic              beatsPrev;
      logic              lowVld;
      logic [DATA_W-1:0] lowKey;
      logic [TAG_W-1:0]  lowTag;
      logic              upVld;
      logic [DATA_W-1:0] upKey;
      logic [TAG_W-1:0]  upTag;

      if (i == 0) begin : gBottom
         assign beatsPrev = 1'b0;
         assign lowVld    = 1'b0;
         assign lowKey    = '0;
         assign lowTag    = '0;
      end else begin : gLower
         assign beatsPrev = beatsW[i-1];
         assign lowVld    = vldW[i-1];
         assign lowKey    = keyW[i-1];
         assign lowTag    = tagW[i-1];
      end

      if (i == DEPTH - 1) begin : gTop
         assign upVld = 1'b0;
         assign upKey = '0;
         assign upTag = '0;
      end else begin : gUpper
         assign upVld = vldW[i+1];
         assign upKey = keyW[i+1];
         assign upTag = tagW[i+1];
      end

      sort_cell #(
         .DATA_W (DATA_W),
         .TAG_W  (TAG_W)
      ) uCell (
         .clk          (clk),
         .rst_n        (rst_n),
         .clear_i      (clear_i),
         .insert_i     (inAcc),
         .shift_i      (outAcc),
         .descend_i    (descend_q),
         .in_key_i     (bus.in_key),
         .in_tag_i     (bus.in_tag),
         .beats_prev_i (beatsPrev),
         .lower_vld_i  (lowVld),
         .lower_key_i  (lowKey),
         .lower_tag_i  (lowTag),
         .upper_vld_i  (upVld),
         .upper_key_i  (upKey),
         .upper_tag_i  (upTag),
         .beats_o      (beatsW[i]),
         .vld_o        (vldW[i]),
         .key_o        (keyW[i]),
         .tag_o        (tagW[i])
      );

      assign sorted_keys_o[DATA_W*i +: DATA_W] = keyW[i];
      assign sorted_tags_o[TAG_W*i +: TAG_W]   = tagW[i];
   end

   assign sorted_vld_o  = vldW;
   assign count_o       = count_q;
   assign truncated_o   = truncated_q;

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.out_last  = outLast;
   assign bus.out_key   = keyW[0];
   assign bus.out_tag   = tagW[0];

endmodule
